// File: rtl/ysyx_23060187_wbu_if.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_23060187_wbu_if
// Brief    : EXU->WBU result handshake and LSU read-response channel.
// Revision : 1.0  initial release
// =============================================================================
interface ysyx_23060187_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_wen;
  logic                  in_is_load;
  logic [2:0]            in_funct3;
  logic [1:0]            in_addr_lo;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, mem_rready
  );

  modport slave (
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, mem_rready
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060187_wbu.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_23060187_wbu
// Brief    : Writeback stage: load extraction, GPR write port, instret counter.
//            Optional misaligned-load check: YSYX_23060187_WBU_MISALIGN_CHECK_EN.
// Revision : 1.0  initial release
// =============================================================================
module ysyx_23060187_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  wire                    clk,
  input  wire                    rst_n,
  ysyx_23060187_wbu_if.slave     bus,
  output logic                   rf_wen,
  output logic [ADDR_WIDTH-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata,
  output logic [ADDR_WIDTH-1:0]  busy_rd,
  output logic                   commit,
  output logic [CNT_WIDTH-1:0]   instret,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_in_ready;
  logic                  w_mem_fire;
  logic                  w_misalign;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_instret;

  assign w_in_ready     = (r_state != S_WAIT_MEM);
  assign w_accept       = bus.in_valid & w_in_ready;
  assign w_mem_fire     = (r_state == S_WAIT_MEM) & bus.mem_rvalid;
  assign bus.in_ready   = w_in_ready;
  assign bus.mem_rready = (r_state == S_WAIT_MEM);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (w_accept)
          w_state_nxt = bus.in_is_load ? S_WAIT_MEM : S_WRITE;
        else
          w_state_nxt = S_IDLE;
      end
      S_WAIT_MEM: begin
        if (bus.mem_rvalid)
          w_state_nxt = S_WRITE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane selection uses the address latched with the load, not the live input.
  always_comb begin
    w_byte      = bus.mem_rdata[{r_addr_lo, 3'b000} +: 8];
    w_half      = bus.mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];
    w_load_data = bus.mem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_data    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rd      <= bus.in_rd;
        r_wen     <= bus.in_wen;
        r_funct3  <= bus.in_funct3;
        r_addr_lo <= bus.in_addr_lo;
        r_data    <= bus.in_result;
      end else if (w_mem_fire) begin
        r_data    <= w_load_data;
      end
      // Counting on entry to WRITE makes instret include the commit it accompanies.
      if (w_state_nxt == S_WRITE)
        r_instret <= r_instret + CNT_WIDTH'(1);
    end
  end

`ifdef YSYX_23060187_WBU_MISALIGN_CHECK_EN
  logic r_is_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_is_load <= 1'b0;
    else if (w_accept)
      r_is_load <= bus.in_is_load;
  end

  assign w_misalign = r_is_load &
                      ((((r_funct3 == 3'b001) || (r_funct3 == 3'b101)) && r_addr_lo[0]) ||
                       ((r_funct3 == 3'b010) && (r_addr_lo != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  assign rf_wen       = (r_state == S_WRITE) & r_wen & (r_rd != '0) & ~w_misalign;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_data;
  assign commit       = (r_state == S_WRITE);
  assign misalign_err = (r_state == S_WRITE) & w_misalign;
  assign instret      = r_instret;
  assign busy_rd      = ((r_state != S_IDLE) && r_wen) ? r_rd : '0;

endmodule
`default_nettype wire
